// File: rtl/ohs_pwm_timebase_pkg.sv
// Shared constants for the PWM timebase: default carrier and prescaler widths.
package ohs_pwm_timebase_pkg;

  // Carrier counter, period and duty width.
  localparam int unsigned OHS_CNT_WIDTH    = 16;
  // model_ce prescaler divider width.
  localparam int unsigned OHS_CE_DIV_WIDTH = 8;

endpackage : ohs_pwm_timebase_pkg

// File: rtl/ohs_pwm_timebase_prescaler.sv
// Model clock-enable prescaler: a one-clock model_ce strobe every ce_div+1 clocks
// while enabled. The counter and strobe are held at zero while disabled.
module ohs_ce_prescaler
  import ohs_pwm_timebase_pkg::*;
#(
  parameter int unsigned CE_DIV_WIDTH = OHS_CE_DIV_WIDTH
) (
  input  logic                    aclk,
  input  logic                    resetn,
  input  logic                    enable,
  input  logic [CE_DIV_WIDTH-1:0] ce_div,
  output logic                    model_ce
);

  logic [CE_DIV_WIDTH-1:0] r_pre_cnt;
  logic                    r_model_ce;

  // Count 0..ce_div. The compare uses >= so that lowering ce_div below the
  // current count wraps to 0 at the next step instead of running to overflow.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      r_pre_cnt  <= '0;
      r_model_ce <= 1'b0;
    end else if (!enable) begin
      r_pre_cnt  <= '0;
      r_model_ce <= 1'b0;
    end else if (r_pre_cnt >= ce_div) begin
      r_pre_cnt  <= '0;
      r_model_ce <= 1'b1;
    end else begin
      r_pre_cnt  <= r_pre_cnt + 1'b1;
      r_model_ce <= 1'b0;
    end
  end

  assign model_ce = r_model_ce;

endmodule : ohs_ce_prescaler

// File: rtl/ohs_pwm_timebase.sv
// PWM timebase for the boost model. It generates model_ce and the S1_pwm gate.
// The carrier steps only on model_ce. Period and duty are applied through
// shadow registers at carrier wrap, so the gate never glitches mid-period.
module ohs_pwm_timebase
  import ohs_pwm_timebase_pkg::*;
#(
  parameter int unsigned CNT_WIDTH    = OHS_CNT_WIDTH,
  parameter int unsigned CE_DIV_WIDTH = OHS_CE_DIV_WIDTH
) (
  input  logic                    aclk,
  input  logic                    resetn,
  input  logic                    enable,
  input  logic [CE_DIV_WIDTH-1:0] ce_div,
  input  logic [CNT_WIDTH-1:0]    period,
  input  logic [CNT_WIDTH-1:0]    duty_in,
  input  logic                    duty_valid,
  output logic                    duty_ready,
  output logic                    model_ce,
  output logic                    S1_pwm,
  output logic                    period_sync,
  output logic [CNT_WIDTH-1:0]    carrier
);

  logic                 w_model_ce;
  logic                 w_wrap;
  logic                 w_accept;
  logic [CNT_WIDTH-1:0] w_carrier_nxt;
  logic [CNT_WIDTH-1:0] w_period_nxt;
  logic [CNT_WIDTH-1:0] w_duty_nxt;
  logic                 w_s1_nxt;

  logic [CNT_WIDTH-1:0] r_carrier;
  logic [CNT_WIDTH-1:0] r_period_sh;
  logic [CNT_WIDTH-1:0] r_duty_sh;
  logic [CNT_WIDTH-1:0] r_pending;
  logic                 r_pending_full;
  logic                 r_s1_pwm;
  logic                 r_period_sync;

  ohs_ce_prescaler #(
    .CE_DIV_WIDTH (CE_DIV_WIDTH)
  ) u_prescaler (
    .aclk     (aclk),
    .resetn   (resetn),
    .enable   (enable),
    .ce_div   (ce_div),
    .model_ce (w_model_ce)
  );

  // Next carrier step. A zero period counts as a wrap on every tick, so the
  // shadows keep reloading until a usable period arrives.
  always_comb begin
    w_wrap        = 1'b0;
    w_carrier_nxt = r_carrier + 1'b1;
    w_period_nxt  = r_period_sh;
    w_duty_nxt    = r_duty_sh;
    if ((r_period_sh == '0) || (r_carrier == (r_period_sh - 1'b1))) begin
      w_wrap        = 1'b1;
      w_carrier_nxt = '0;
      w_period_nxt  = period;
      if (r_pending_full) begin
        w_duty_nxt = r_pending;
      end
    end
    // Gate follows the post-update carrier and shadows. It is forced low while
    // the period is zero.
    w_s1_nxt = (w_period_nxt != '0) && (w_carrier_nxt < w_duty_nxt);
  end

  assign w_accept = duty_valid && !r_pending_full;

  // Carrier, shadow registers and registered outputs. While disabled, the
  // shadows track the live inputs so the first enabled period uses fresh values.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      r_carrier     <= '0;
      r_period_sh   <= '0;
      r_duty_sh     <= '0;
      r_s1_pwm      <= 1'b0;
      r_period_sync <= 1'b0;
    end else if (!enable) begin
      r_carrier     <= '0;
      r_period_sh   <= period;
      r_s1_pwm      <= 1'b0;
      r_period_sync <= 1'b0;
      if (r_pending_full) begin
        r_duty_sh <= r_pending;
      end
    end else if (w_model_ce) begin
      r_carrier     <= w_carrier_nxt;
      r_period_sh   <= w_period_nxt;
      r_duty_sh     <= w_duty_nxt;
      r_s1_pwm      <= w_s1_nxt;
      r_period_sync <= w_wrap;
    end else begin
      r_period_sync <= 1'b0;
    end
  end

  // Single-entry duty slot. An accept needs the slot to be empty, and a
  // release needs it to be full, so the two never collide. An accept in the
  // same clock as a wrap stays pending until the following wrap.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      r_pending      <= '0;
      r_pending_full <= 1'b0;
    end else if (w_accept) begin
      r_pending      <= duty_in;
      r_pending_full <= 1'b1;
    end else if (r_pending_full && (!enable || (w_model_ce && w_wrap))) begin
      r_pending_full <= 1'b0;
    end
  end

  assign duty_ready  = !r_pending_full;
  assign model_ce    = w_model_ce;
  assign S1_pwm      = r_s1_pwm;
  assign period_sync = r_period_sync;
  assign carrier     = r_carrier;

endmodule : ohs_pwm_timebase

// File: tb/tb_ohs_pwm_timebase.sv
// Self-checking bench for ohs_pwm_timebase. For each model_ce tick, it queues
// the expected carrier, gate and period_sync values, and compares them after
// the tick.
module tb_ohs_pwm_timebase;

  logic        aclk = 1'b0;
  logic        resetn;
  logic        enable;
  logic [7:0]  ce_div;
  logic [15:0] period;
  logic [15:0] duty_in;
  logic        duty_valid;
  logic        duty_ready;
  logic        model_ce;
  logic        S1_pwm;
  logic        period_sync;
  logic [15:0] carrier;

  typedef struct packed {
    logic [15:0] car;
    logic        s1;
    logic        ps;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic ce_d = 1'b0;
  int   n_total = 0;
  int   n_bad   = 0;

  ohs_pwm_timebase #(
    .CNT_WIDTH    (16),
    .CE_DIV_WIDTH (8)
  ) dut (
    .aclk        (aclk),
    .resetn      (resetn),
    .enable      (enable),
    .ce_div      (ce_div),
    .period      (period),
    .duty_in     (duty_in),
    .duty_valid  (duty_valid),
    .duty_ready  (duty_ready),
    .model_ce    (model_ce),
    .S1_pwm      (S1_pwm),
    .period_sync (period_sync),
    .carrier     (carrier)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input int c, input bit s1, input bit ps);
    exp_t e;
    e.car = 16'(c);
    e.s1  = s1;
    e.ps  = ps;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic send_duty(input logic [15:0] d);
    bit rdy;
    rdy        = 1'b0;
    duty_in    = d;
    duty_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      rdy = duty_ready;
      step(1);
      if (rdy) break;
    end
    duty_valid = 1'b0;
    check("duty_accept", 32'(rdy), 32'd1);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0) break;
      step(1);
    end
    check("sb_drain", 32'(sb.size()), 32'd0);
  endtask

  // The outputs after the edge where model_ce was high are one queued tick.
  always @(negedge aclk) begin
    if (ce_d && (sb.size() > 0)) begin
      mon_e = sb.pop_front();
      check("carrier", 32'(carrier),     32'(mon_e.car));
      check("s1_pwm",  32'(S1_pwm),      32'(mon_e.s1));
      check("psync",   32'(period_sync), 32'(mon_e.ps));
    end
    ce_d = model_ce;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int c;
    int d;
    resetn     = 1'b0;
    enable     = 1'b0;
    ce_div     = 8'd0;
    period     = 16'd0;
    duty_in    = 16'd0;
    duty_valid = 1'b0;
    step(2);
    check("rst_ce",    32'(model_ce),    32'd0);
    check("rst_s1",    32'(S1_pwm),      32'd0);
    check("rst_psync", 32'(period_sync), 32'd0);
    check("rst_car",   32'(carrier),     32'd0);
    check("rst_rdy",   32'(duty_ready),  32'd1);
    resetn = 1'b1;
    step(1);

    // model_ce cadence with ce_div=3
    ce_div = 8'd3;
    period = 16'd10;
    step(1);
    enable = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      check("ce_div3", 32'(model_ce), 32'((k % 4) == 0));
    end
    enable = 1'b0;
    step(2);

    // period 10, duty 4 -> 7 -> 9 with a stalled second request
    ce_div = 8'd0;
    period = 16'd10;
    send_duty(16'd4);
    step(2);
    check("dis_car", 32'(carrier), 32'd0);
    check("dis_s1",  32'(S1_pwm),  32'd0);
    for (int k = 1; k <= 35; k++) begin
      c = k % 10;
      d = (k < 20) ? 4 : ((k < 30) ? 7 : 9);
      push(c, c < d, c == 0);
    end
    enable = 1'b1;
    step(15);
    duty_in    = 16'd7;
    duty_valid = 1'b1;
    step(1);
    check("rdy_after_acc", 32'(duty_ready), 32'd0);
    duty_in = 16'd9;
    for (int e = 17; e <= 22; e++) begin
      step(1);
      check("stall_rdy", 32'(duty_ready), 32'(e == 21));
    end
    duty_valid = 1'b0;
    wait_drain(60);
    enable = 1'b0;
    step(2);

    // duty 0 -> always low
    send_duty(16'd0);
    step(2);
    for (int k = 1; k <= 20; k++) push(k % 10, 1'b0, (k % 10) == 0);
    enable = 1'b1;
    wait_drain(40);
    enable = 1'b0;
    step(1);

    // duty 12 over period 10 -> always high
    send_duty(16'd12);
    step(2);
    for (int k = 1; k <= 20; k++) push(k % 10, 1'b1, (k % 10) == 0);
    enable = 1'b1;
    wait_drain(40);
    enable = 1'b0;
    step(2);

    // zero period, then 2/5 PWM
    period = 16'd0;
    send_duty(16'd3);
    step(2);
    for (int k = 1; k <= 6; k++) push(0, 1'b0, 1'b1);
    for (int k = 7; k <= 20; k++) begin
      c = (k - 7) % 5;
      push(c, c < 2, c == 0);
    end
    enable = 1'b1;
    step(6);
    duty_in    = 16'd2;
    duty_valid = 1'b1;
    step(1);
    duty_valid = 1'b0;
    period     = 16'd5;
    check("rdy_p0_pend", 32'(duty_ready), 32'd0);
    wait_drain(40);
    enable = 1'b0;
    step(2);

    // async reset at carrier 6 with a pending duty
    period = 16'd10;
    send_duty(16'd4);
    step(2);
    enable = 1'b1;
    step(5);
    duty_in    = 16'd8;
    duty_valid = 1'b1;
    step(1);
    duty_valid = 1'b0;
    step(1);
    check("car_pre_rst", 32'(carrier),    32'd6);
    check("rdy_pre_rst", 32'(duty_ready), 32'd0);
    check("ce_pre_rst",  32'(model_ce),   32'd1);
    #2;
    resetn = 1'b0;
    #1;
    check("arst_ce",    32'(model_ce),    32'd0);
    check("arst_s1",    32'(S1_pwm),      32'd0);
    check("arst_psync", 32'(period_sync), 32'd0);
    check("arst_car",   32'(carrier),     32'd0);
    check("arst_rdy",   32'(duty_ready),  32'd1);
    step(2);
    // The pending duty 8 is lost. duty_sh stays 0, so the gate stays low.
    for (int k = 1; k <= 15; k++) begin
      c = (k - 1) % 10;
      push(c, 1'b0, c == 0);
    end
    resetn = 1'b1;
    #1;
    check("rel_car", 32'(carrier),    32'd0);
    check("rel_rdy", 32'(duty_ready), 32'd1);
    wait_drain(40);
    enable = 1'b0;
    step(2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_ohs_pwm_timebase
